md_unit: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage
//   of the 5-stage pipeline. Supersedes the fixed-latency mult/div block.

---
 rtl/md_unit_if.sv | 21 ++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: E-stage launch, mthi/mtlo writes, flush, and HI/LO status.
`timescale 1ns/1ps
interface md_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mt_we;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_data;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src_a, src_b, mt_we, mt_sel, mt_data, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, src_a, src_b, mt_we, mt_sel, mt_data, flush,
                  output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and madd/msub accumulate.
// Operands are captured at launch; the result is formed from the captured copies
// and written to HI/LO only on the commit edge, so a flush leaves HI/LO untouched.
`timescale 1ns/1ps
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int EN_MACC     = 1
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hic_q, loc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               launch, commit, mt_wr, legal, is_div;

  logic               sgn, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b, uq, ur, q, r;
  logic [2*WIDTH-1:0] pa, pb, prod, acc, res;

  assign legal  = ~bus.op[2] | (EN_MACC != 0);
  assign is_div = (bus.op[2:1] == 2'b01);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and launch/commit/mt-write decode; flush outranks everything.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    commit  = 1'b0;
    mt_wr   = 1'b0;
    case (state_q)
      IDLE: if (!bus.flush) begin
        if (bus.start && legal) begin
          launch  = 1'b1;
          state_d = RUN;
        end else if (!bus.start && bus.mt_we) begin
          mt_wr = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result from captured operands; signed division via magnitudes so INT_MIN/-1 wraps to INT_MIN, rem 0.
  always_comb begin
    sgn   = ~op_q[0];
    neg_a = sgn & a_q[WIDTH-1];
    neg_b = sgn & b_q[WIDTH-1];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    uq    = mag_a / mag_b;
    ur    = mag_a % mag_b;
    q     = (neg_a ^ neg_b) ? -uq : uq;
    r     = neg_a ? -ur : ur;
    if (b_q == '0) begin
      q = '1;
      r = a_q;
    end
    pa   = {{WIDTH{neg_a}}, a_q};
    pb   = {{WIDTH{neg_b}}, b_q};
    prod = pa * pb;
    acc  = {hic_q, loc_q};
    case (op_q)
      3'd0, 3'd1: res = prod;
      3'd2, 3'd3: res = {r, q};
      3'd4, 3'd5: res = acc + prod;
      default:    res = acc - prod;
    endcase
  end

  // Operand capture, latency counter, HI/LO update and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hic_q  <= '0;
      loc_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (launch) begin
        op_q  <= bus.op;
        a_q   <= bus.src_a;
        b_q   <= bus.src_b;
        hic_q <= hi_q;
        loc_q <= lo_q;
        cnt_q <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state_q == RUN) begin
        if (bus.flush || commit) cnt_q <= '0;
        else                     cnt_q <= cnt_q - CW'(1);
      end
      if (commit) begin
        hi_q <= res[2*WIDTH-1:WIDTH];
        lo_q <= res[WIDTH-1:0];
      end else if (mt_wr) begin
        if (bus.mt_sel) hi_q <= bus.mt_data;
        else            lo_q <= bus.mt_data;
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit (WIDTH=32, 5/10 cycle latencies): a transaction-level model
// (result computed at launch, applied at a deadline cycle) is compared every cycle,
// and directed operations are pinned to hand-computed HI/LO values and latencies.
`timescale 1ns/1ps
module tb_md_unit;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(ML), .DIV_CYCLES(DL), .EN_MACC(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one op as {HI, LO}.
  function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] h, input logic [31:0] l);
    logic [63:0] ps, pu, acc;
    int sa, sb;
    sa  = a;
    sb  = b;
    acc = {h, l};
    ps  = longint'(sa) * longint'(sb);
    pu  = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: calc = ps;
      3'd1: calc = pu;
      3'd2: begin
        if (b == 0) calc = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) calc = {32'h0, 32'h8000_0000};
        else calc = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) calc = {a, 32'hFFFF_FFFF};
        else calc = {a % b, a / b};
      end
      3'd4: calc = acc + ps;
      3'd5: calc = acc + pu;
      3'd6: calc = acc - ps;
      default: calc = acc - pu;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  logic [63:0] pend;
  longint      cyc, deadline;

  // Model: a launched op is a pending {HI,LO} value due at a fixed cycle number.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; pend = 0; cyc = 0; deadline = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (bus.flush) m_busy = 0;
        else if (cyc == deadline) begin
          {m_hi, m_lo} = pend;
          m_busy = 0;
          m_done = 1;
        end
      end else if (!bus.flush) begin
        if (bus.start) begin
          pend     = calc(bus.op, bus.src_a, bus.src_b, m_hi, m_lo);
          m_busy   = 1;
          deadline = cyc + ((bus.op == 3'd2 || bus.op == 3'd3) ? DL : ML);
        end else if (bus.mt_we) begin
          if (bus.mt_sel) m_hi = bus.mt_data;
          else            m_lo = bus.mt_data;
        end
      end
      cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("hi",   64'(bus.hi),   64'(m_hi));
    chk("lo",   64'(bus.lo),   64'(m_lo));
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    int n;
    bit fin;
    @(posedge clk); #2;
    bus.start = 1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #2;
    bus.start = 0;
    n = 0; fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else fin = 1;
    end
    chk({name, "_finished"}, 64'(fin), 64'd1);
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_done"}, 64'(bus.done), 64'd1);
    chk({name, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({name, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] data);
    @(posedge clk); #2;
    bus.mt_we = 1; bus.mt_sel = sel; bus.mt_data = data;
    @(posedge clk); #2;
    bus.mt_we = 0;
  endtask

  task automatic wait_idle(input string name);
    bit fin;
    fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (!bus.busy) fin = 1;
    end
    chk({name, "_idle"}, 64'(fin), 64'd1);
  endtask

  initial begin
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
    bus.mt_we = 0; bus.mt_sel = 0; bus.mt_data = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk); #2;
    reset = 1;

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("div_zero", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);

    // Accumulate chain from HI=0, LO=0xFFFFFFFF.
    mt_write(1'b1, 32'h0);
    mt_write(1'b0, 32'hFFFF_FFFF);
    run_op("maddu", 3'd5, 32'd1, 32'd1, 32'd1, 32'd0, 5);
    run_op("msub", 3'd6, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFE, 5);

    // mthi in IDLE touches only HI.
    mt_write(1'b1, 32'h1234);
    @(negedge clk);
    chk("mthi_hi", 64'(bus.hi), 64'h1234);
    chk("mthi_lo", 64'(bus.lo), 64'hFFFF_FFFE);

    // mt_we during RUN is dropped.
    @(posedge clk); #2;
    bus.start = 1; bus.op = 3'd0; bus.src_a = 32'd2; bus.src_b = 32'd3;
    @(posedge clk); #2;
    bus.start = 0; bus.mt_we = 1; bus.mt_sel = 1; bus.mt_data = 32'hDEAD;
    @(posedge clk); #2;
    bus.mt_we = 0;
    wait_idle("mt_run");
    chk("mt_run_hi", 64'(bus.hi), 64'h0);
    chk("mt_run_lo", 64'(bus.lo), 64'h6);

    // Flush on the third busy cycle: no commit, no done.
    @(posedge clk); #2;
    bus.start = 1; bus.op = 3'd0; bus.src_a = 32'd7; bus.src_b = 32'd7;
    @(posedge clk); #2;
    bus.start = 0;
    repeat (2) @(posedge clk);
    #2 bus.flush = 1;
    @(posedge clk); #2;
    bus.flush = 0;
    @(negedge clk);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    repeat (8) @(negedge clk);
    chk("flush_hi", 64'(bus.hi), 64'h0);
    chk("flush_lo", 64'(bus.lo), 64'h6);

    // start beats a same-cycle mt write.
    @(posedge clk); #2;
    bus.start = 1; bus.op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd3;
    bus.mt_we = 1; bus.mt_sel = 0; bus.mt_data = 32'hAAAA;
    @(posedge clk); #2;
    bus.start = 0; bus.mt_we = 0;
    wait_idle("st_mt");
    chk("st_mt_lo", 64'(bus.lo), 64'h9);

    // flush in IDLE drops start and mt_we.
    @(posedge clk); #2;
    bus.flush = 1; bus.start = 1; bus.op = 3'd0; bus.src_a = 32'd4; bus.src_b = 32'd4;
    bus.mt_we = 1; bus.mt_sel = 1; bus.mt_data = 32'h5555;
    @(posedge clk); #2;
    bus.flush = 0; bus.start = 0; bus.mt_we = 0;
    @(negedge clk);
    chk("iflush_busy", 64'(bus.busy), 64'd0);
    chk("iflush_hi", 64'(bus.hi), 64'h0);
    chk("iflush_lo", 64'(bus.lo), 64'h9);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #2;
    bus.start = 1; bus.op = 3'd1; bus.src_a = 32'd5; bus.src_b = 32'd5;
    @(posedge clk); #2;
    bus.start = 0;
    @(posedge clk); #2;
    reset = 0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk); #2;
    reset = 1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
